// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between the CPU (fixed priority) and a debug master; CPU reads are combinational.
// Debug grant comes 1 cycle after the request when the CPU is idle and at most STARVE_LIMIT cycles otherwise; the CPU is held back with cpu_stall.
module dmem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req_r,
  input  logic              cpu_req_w,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {
    CPU_OWN = 1'b0,
    DBG     = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LP_STARVE_MAX = CNT_W'(STARVE_LIMIT - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_starve_cnt;
  logic [CNT_W-1:0]  w_starve_nxt;
  logic              r_dbg_rvalid;
  logic [DATA_W-1:0] r_dbg_rdata;
  logic              w_cpu_busy;
  logic              w_dbg_slot;
  logic              w_starved;
  logic              w_take_dbg;
  logic              w_dbg_rd;

  assign w_cpu_busy = cpu_req_r | cpu_req_w;
  assign w_dbg_slot = (r_state == DBG);
  assign w_starved  = (r_starve_cnt == LP_STARVE_MAX);
  assign w_take_dbg = dbg_req & (~w_cpu_busy | w_starved);
  assign w_dbg_rd   = w_dbg_slot & ~dbg_we;

  assign cpu_rdata  = mem_rdata;
  assign dbg_rvalid = r_dbg_rvalid;
  assign dbg_rdata  = r_dbg_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= CPU_OWN;
      r_starve_cnt <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_starve_nxt = r_starve_cnt;
    mem_en       = w_cpu_busy;
    mem_we       = cpu_req_w;
    mem_addr     = cpu_addr;
    mem_wdata    = cpu_wdata;
    cpu_stall    = 1'b0;
    dbg_gnt      = 1'b0;
    case (r_state)
      CPU_OWN: begin
        // A withdrawn request forfeits any accumulated starvation credit.
        if (!dbg_req) begin
          w_starve_nxt = '0;
        end else if (w_take_dbg) begin
          w_state_nxt  = DBG;
          w_starve_nxt = '0;
        end else if (w_cpu_busy) begin
          w_starve_nxt = r_starve_cnt + CNT_W'(1);
        end
      end
      DBG: begin
        mem_en       = 1'b1;
        mem_we       = dbg_we;
        mem_addr     = dbg_addr;
        mem_wdata    = dbg_wdata;
        cpu_stall    = 1'b1;
        dbg_gnt      = 1'b1;
        w_state_nxt  = CPU_OWN;
        w_starve_nxt = '0;
      end
      default: begin
        w_state_nxt  = CPU_OWN;
        w_starve_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dbg_rvalid <= 1'b0;
      r_dbg_rdata  <= '0;
    end else begin
      r_dbg_rvalid <= w_dbg_rd;
      if (w_dbg_rd) begin
        r_dbg_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: vector table for the CPU path, scoreboard for debug read returns,
// hand-written sequences for starvation, back-to-back requests and reset mid-slot.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req_r = 1'b0;
  logic        cpu_req_w = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        dbg_req = 1'b0;
  logic        dbg_we = 1'b0;
  logic [31:0] dbg_addr = '0;
  logic [31:0] dbg_wdata = '0;
  logic        dbg_gnt;
  logic        dbg_rvalid;
  logic [31:0] dbg_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic        bd_we = 1'b0;
  logic [7:0]  bd_addr = '0;
  logic [31:0] bd_wdata = '0;
  logic [31:0] mem [0:255];

  int n_chk = 0;
  int n_err = 0;
  int n_stall;
  int n_stored;
  logic [31:0] sb_q[$];

  typedef struct {
    logic        r;
    logic        w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        en;
    logic        we;
    logic [31:0] rdata;
  } vec_t;
  vec_t vt[6];

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req_r(cpu_req_r), .cpu_req_w(cpu_req_w), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: combinational read, write on the rising edge, plus a bench backdoor.
  assign mem_rdata = mem[mem_addr[7:0]];
  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_wdata;
    else if (mem_en && mem_we) mem[mem_addr[7:0]] <= mem_wdata;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic expect_rvalid(input string nm);
    chk({nm, "_rvalid"}, {31'd0, dbg_rvalid}, 32'd1);
    if (dbg_rvalid) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL %s_sb: read return with empty scoreboard, data 0x%08h", nm, dbg_rdata);
      end else begin
        chk({nm, "_rdata"}, dbg_rdata, sb_q.pop_front());
      end
    end
  endtask

  // Raises a debug request, waits (bounded) for the grant, checks the slot, then withdraws.
  task automatic dbg_xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input int exp_lat, input string nm);
    int lat;
    int k;
    lat = -1;
    k = 0;
    step();
    dbg_req = 1'b1;
    dbg_we = we;
    dbg_addr = addr;
    dbg_wdata = wdata;
    while (lat < 0 && k < 32) begin
      @(negedge clk);
      if (dbg_gnt) begin
        lat = k;
        chk({nm, "_stall"}, {31'd0, cpu_stall}, 32'd1);
        chk({nm, "_en"}, {31'd0, mem_en}, 32'd1);
        chk({nm, "_we"}, {31'd0, mem_we}, {31'd0, we});
        chk({nm, "_addr"}, mem_addr, addr);
        if (we) chk({nm, "_wdata"}, mem_wdata, wdata);
      end
      k++;
    end
    chk({nm, "_lat"}, lat, exp_lat);
    @(posedge clk);
    #1;
    dbg_req = 1'b0;
  endtask

  // CPU storing every cycle; a store is accepted only in cycles without cpu_stall.
  task automatic cpu_store_run(input int ncyc, output int nstall, output int nstored);
    int idx;
    idx = 0;
    nstall = 0;
    for (int c = 0; c < ncyc; c++) begin
      step();
      cpu_req_w = 1'b1;
      cpu_addr = 32'h40 + idx;
      cpu_wdata = 32'h1000 + idx;
      @(negedge clk);
      if (cpu_stall) nstall++;
      else idx++;
    end
    step();
    cpu_req_w = 1'b0;
    nstored = idx;
  endtask

  initial begin
    vt[0] = '{r:1'b1, w:1'b0, addr:32'h10, wdata:32'h0,        en:1'b1, we:1'b0, rdata:32'hCAFEF00D};
    vt[1] = '{r:1'b0, w:1'b0, addr:32'h14, wdata:32'h0,        en:1'b0, we:1'b0, rdata:32'h0BADBEEF};
    vt[2] = '{r:1'b0, w:1'b1, addr:32'h30, wdata:32'h0000A5A5, en:1'b1, we:1'b1, rdata:32'h0};
    vt[3] = '{r:1'b1, w:1'b0, addr:32'h30, wdata:32'h0,        en:1'b1, we:1'b0, rdata:32'h0000A5A5};
    vt[4] = '{r:1'b1, w:1'b1, addr:32'h34, wdata:32'h00000077, en:1'b1, we:1'b1, rdata:32'h0};
    vt[5] = '{r:1'b1, w:1'b0, addr:32'h34, wdata:32'h0,        en:1'b1, we:1'b0, rdata:32'h00000077};

    // Clear and preload memory while reset is held.
    for (int i = 0; i < 128; i++) begin
      step();
      bd_we = 1'b1;
      bd_addr = 8'(i);
      bd_wdata = (i == 'h10) ? 32'hCAFEF00D : (i == 'h14) ? 32'h0BADBEEF : 32'h0;
    end
    step();
    bd_we = 1'b0;
    @(negedge clk);
    chk("rst_stall", {31'd0, cpu_stall}, 32'd0);
    chk("rst_gnt", {31'd0, dbg_gnt}, 32'd0);
    chk("rst_rvalid", {31'd0, dbg_rvalid}, 32'd0);
    chk("rst_rdata", dbg_rdata, 32'd0);
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    step();
    rst = 1'b0;

    // CPU path with no debug traffic.
    for (int v = 0; v < 6; v++) begin
      step();
      cpu_req_r = vt[v].r;
      cpu_req_w = vt[v].w;
      cpu_addr = vt[v].addr;
      cpu_wdata = vt[v].wdata;
      @(negedge clk);
      chk($sformatf("vec%0d_en", v), {31'd0, mem_en}, {31'd0, vt[v].en});
      chk($sformatf("vec%0d_we", v), {31'd0, mem_we}, {31'd0, vt[v].we});
      chk($sformatf("vec%0d_addr", v), mem_addr, vt[v].addr);
      if (vt[v].w) chk($sformatf("vec%0d_wdata", v), mem_wdata, vt[v].wdata);
      chk($sformatf("vec%0d_rdata", v), cpu_rdata, vt[v].rdata);
      chk($sformatf("vec%0d_stall", v), {31'd0, cpu_stall}, 32'd0);
    end
    step();
    cpu_req_r = 1'b0;
    cpu_req_w = 1'b0;

    // Idle-CPU debug write, then CPU reads it back.
    dbg_xfer(1'b1, 32'h20, 32'h12345678, 1, "t2");
    cpu_req_r = 1'b1;
    cpu_addr = 32'h20;
    @(negedge clk);
    chk("t2_cpu_rd", cpu_rdata, 32'h12345678);
    step();
    cpu_req_r = 1'b0;

    // Idle-CPU debug read: rvalid for exactly one cycle, data held afterwards.
    sb_q.push_back(32'h12345678);
    dbg_xfer(1'b0, 32'h20, 32'h0, 1, "t3");
    @(negedge clk);
    expect_rvalid("t3");
    step();
    @(negedge clk);
    chk("t3_rvalid_drop", {31'd0, dbg_rvalid}, 32'd0);
    chk("t3_rdata_hold", dbg_rdata, 32'h12345678);

    // Withdrawn request under a busy CPU clears the starvation count.
    cpu_req_r = 1'b1;
    cpu_addr = 32'h10;
    dbg_req = 1'b1;
    dbg_we = 1'b0;
    dbg_addr = 32'h14;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("wd_nogrant%0d", c), {31'd0, dbg_gnt}, 32'd0);
      step();
    end
    dbg_req = 1'b0;
    sb_q.push_back(32'h0BADBEEF);
    dbg_xfer(1'b0, 32'h14, 32'h0, 8, "wd");
    @(negedge clk);
    expect_rvalid("wd");
    step();
    cpu_req_r = 1'b0;

    // CPU storing every cycle: forced grant after 8 cycles, exactly one stalled store.
    fork
      cpu_store_run(14, n_stall, n_stored);
      dbg_xfer(1'b1, 32'h70, 32'hBEEF0070, 8, "t4");
    join
    chk("t4_nstall", n_stall, 32'd1);
    chk("t4_nstored", n_stored, 32'd13);
    for (int i = 0; i < 13; i++) chk($sformatf("t4_mem%0d", i), mem[8'h40 + 8'(i)], 32'h1000 + i);
    chk("t4_mem_past_end", mem[8'h4D], 32'h0);
    chk("t4_mem_dbg", mem[8'h70], 32'hBEEF0070);

    // Held request with idle CPU: grants on alternate cycles only.
    step();
    dbg_req = 1'b1;
    dbg_we = 1'b0;
    dbg_addr = 32'h20;
    for (int i = 0; i < 3; i++) sb_q.push_back(32'h12345678);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      chk($sformatf("t5_gnt%0d", k), {31'd0, dbg_gnt}, {31'd0, (k % 2 == 1)});
      chk($sformatf("t5_stall%0d", k), {31'd0, cpu_stall}, {31'd0, (k % 2 == 1)});
      if (k >= 2 && k % 2 == 0) expect_rvalid($sformatf("t5_rd%0d", k));
      else chk($sformatf("t5_norv%0d", k), {31'd0, dbg_rvalid}, 32'd0);
      step();
      if (k == 5) dbg_req = 1'b0;
    end
    dbg_req = 1'b0;

    // Reset in the middle of a debug write slot.
    step();
    dbg_req = 1'b1;
    dbg_we = 1'b1;
    dbg_addr = 32'h24;
    dbg_wdata = 32'hFFFF0000;
    step();
    chk("t6_gnt_pre", {31'd0, dbg_gnt}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_stall", {31'd0, cpu_stall}, 32'd0);
    chk("t6_gnt", {31'd0, dbg_gnt}, 32'd0);
    chk("t6_rvalid", {31'd0, dbg_rvalid}, 32'd0);
    chk("t6_mem_we", {31'd0, mem_we}, 32'd0);
    chk("t6_cnt", {28'd0, dut.r_starve_cnt}, 32'd0);
    chk("t6_rdata", dbg_rdata, 32'd0);
    dbg_req = 1'b0;
    step();
    chk("t6_mem", mem[8'h24], 32'h0);
    rst = 1'b0;
    step();
    @(negedge clk);
    chk("t6_post_gnt", {31'd0, dbg_gnt}, 32'd0);

    chk("sb_empty", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
